// File: rtl/snax_hwpe_regfile_pkg.sv
// Shared definitions for the HWPE peripheral register file: job states,
// register offsets above the CFG window and STATUS bit layout.
package snax_hwpe_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RUNNING = 2'd2
    } job_state_e;

    // Word offsets relative to NumRegs
    localparam int unsigned TRIG_OFF   = 0;
    localparam int unsigned STATUS_OFF = 1;
    localparam int unsigned JOBCNT_OFF = 2;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    function automatic logic [31:0] status_word(input logic busy, input logic done_sticky);
        logic [31:0] w;
        w = '0;
        w[STATUS_BUSY_BIT] = busy;
        w[STATUS_DONE_BIT] = done_sticky;
        return w;
    endfunction

endpackage

// File: rtl/snax_hwpe_job_fsm.sv
// Job sequencer: IDLE -> START -> RUNNING handshake, sticky done flag and
// completed-job counter.
module snax_hwpe_job_fsm
    import snax_hwpe_regfile_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trigger_i,
    input  logic        done_i,
    input  logic        status_rd_i,
    input  logic        jobcnt_clr_i,
    output logic        start_o,
    output logic        busy_o,
    output logic        done_sticky_o,
    output logic [31:0] jobcnt_o
);

    job_state_e state_q, state_d;
    logic       job_done;

    assign job_done = (state_q == RUNNING) && done_i;

    // NOTE: next-state logic assigns a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger_i) state_d = START;
            START:   state_d = RUNNING;
            RUNNING: if (done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            done_sticky_o <= 1'b0;
            jobcnt_o      <= '0;
        end else begin
            state_q <= state_d;
            // Completion wins over the read-to-clear of the same cycle
            if (job_done)
                done_sticky_o <= 1'b1;
            else if (status_rd_i)
                done_sticky_o <= 1'b0;
            if (jobcnt_clr_i)
                jobcnt_o <= job_done ? 32'd1 : 32'd0;
            else if (job_done)
                jobcnt_o <= jobcnt_o + 32'd1;
        end
    end

    assign start_o = (state_q == START);
    assign busy_o  = (state_q != IDLE);

endmodule

// File: rtl/snax_hwpe_periph_regfile.sv
// Responder end of the HWPE peripheral interface: address decode, grant,
// CFG storage and registered read responses around the job FSM.
module snax_hwpe_periph_regfile
    import snax_hwpe_regfile_pkg::*;
#(
    parameter int unsigned NumRegs = 8,
    parameter int unsigned IdWidth = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [31:0]             add_i,
    input  logic                    wen_i,
    input  logic [3:0]              be_i,
    input  logic [31:0]             data_i,
    input  logic [IdWidth-1:0]      id_i,
    output logic [31:0]             r_data_o,
    output logic                    r_valid_o,
    output logic [IdWidth-1:0]      r_id_o,
    output logic [NumRegs*32-1:0]   cfg_o,
    output logic                    start_o,
    input  logic                    done_i,
    output logic                    busy_o
);

    localparam logic [29:0] IDX_CFG_END = 30'(NumRegs);
    localparam logic [29:0] IDX_TRIG    = 30'(NumRegs + TRIG_OFF);
    localparam logic [29:0] IDX_STATUS  = 30'(NumRegs + STATUS_OFF);
    localparam logic [29:0] IDX_JOBCNT  = 30'(NumRegs + JOBCNT_OFF);

    logic [29:0] widx;
    logic        is_cfg;
    logic        xfer;
    logic        rd_xfer;
    logic        wr_xfer;
    logic        done_sticky;
    logic [31:0] jobcnt;
    logic [31:0] rdata;
    logic [31:0] cfg_q [NumRegs];
    logic        unused_addr_lsb;

    assign widx            = add_i[31:2];
    assign unused_addr_lsb = ^add_i[1:0];
    assign is_cfg          = widx < IDX_CFG_END;

    // CFG writes stall during a job; everything else, including STATUS polls, goes through
    assign gnt_o   = req_i && !(!wen_i && is_cfg && busy_o);
    assign xfer    = req_i && gnt_o;
    assign rd_xfer = xfer && wen_i;
    assign wr_xfer = xfer && !wen_i;

    // NOTE: CFG is cleared by reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumRegs); i++) cfg_q[i] <= '0;
        end else if (wr_xfer && is_cfg) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                if (widx == 30'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_i[b]) cfg_q[i][8*b +: 8] <= data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NumRegs); g++) begin : g_cfg_out
        assign cfg_o[g*32 +: 32] = cfg_q[g];
    end

    always_comb begin
        rdata = '0;
        if (is_cfg) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                if (widx == 30'(i)) rdata = cfg_q[i];
            end
        end else if (widx == IDX_STATUS) begin
            rdata = status_word(busy_o, done_sticky);
        end else if (widx == IDX_JOBCNT) begin
            rdata = jobcnt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
            r_id_o    <= '0;
        end else begin
            r_valid_o <= rd_xfer;
            r_data_o  <= rd_xfer ? rdata : 32'd0;
            r_id_o    <= rd_xfer ? id_i : '0;
        end
    end

    snax_hwpe_job_fsm i_job_fsm (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .trigger_i     (wr_xfer && (widx == IDX_TRIG)),
        .done_i        (done_i),
        .status_rd_i   (rd_xfer && (widx == IDX_STATUS)),
        .jobcnt_clr_i  (wr_xfer && (widx == IDX_JOBCNT)),
        .start_o       (start_o),
        .busy_o        (busy_o),
        .done_sticky_o (done_sticky),
        .jobcnt_o      (jobcnt)
    );

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// Scoreboard bench for snax_hwpe_periph_regfile: a register-map model predicts
// grants, job outputs and read responses; a monitor checks responses as they appear.
module tb_snax_hwpe_periph_regfile;

    localparam int NR = 8;
    localparam int IW = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_i, gnt_o, wen_i, done_i;
    logic [31:0]      add_i, data_i, r_data_o;
    logic [3:0]       be_i;
    logic [IW-1:0]    id_i, r_id_o;
    logic             r_valid_o, start_o, busy_o;
    logic [NR*32-1:0] cfg_o;

    snax_hwpe_periph_regfile #(.NumRegs(NR), .IdWidth(IW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .be_i      (be_i),
        .data_i    (data_i),
        .id_i      (id_i),
        .r_data_o  (r_data_o),
        .r_valid_o (r_valid_o),
        .r_id_o    (r_id_o),
        .cfg_o     (cfg_o),
        .start_o   (start_o),
        .done_i    (done_i),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]   data;
        logic [IW-1:0] id;
        int            due;
    } rsp_t;

    rsp_t exp_q[$];

    // Reference model of the register map
    logic [31:0] cfg_m [NR];
    bit          busy_m, sticky_m;
    logic [31:0] jobcnt_m;
    int          trig_cycle = -10;
    int          ncyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [29:0] idx);
        if (idx < NR)       return cfg_m[idx];
        if (idx == NR + 1)  return {30'd0, sticky_m, busy_m};
        if (idx == NR + 2)  return jobcnt_m;
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) cfg_m[i] = '0;
        busy_m     = 1'b0;
        sticky_m   = 1'b0;
        jobcnt_m   = '0;
        trig_cycle = -10;
    endtask

    task automatic check_cfg(input string name);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s[%0d]", name, i), cfg_o[i*32 +: 32], cfg_m[i]);
    endtask

    // One bus cycle: drive at negedge, check combinational/registered outputs, update model
    task automatic cycle(input bit req, input bit wen, input logic [29:0] idx, input logic [3:0] be,
                         input logic [31:0] data, input logic [IW-1:0] id, input bit done);
        bit in_start, exp_gnt, done_eff, was_busy;
        @(negedge clk_i);
        req_i  = req;
        wen_i  = wen;
        add_i  = {idx, 2'b00};
        be_i   = be;
        data_i = data;
        id_i   = id;
        done_i = done;
        #1;
        in_start = busy_m && (ncyc == trig_cycle + 1);
        check("start_o", {31'd0, start_o}, {31'd0, in_start});
        check("busy_o", {31'd0, busy_o}, {31'd0, busy_m});
        check_cfg("cfg_o");
        exp_gnt = req && !(!wen && idx < NR && busy_m);
        check("gnt_o", {31'd0, gnt_o}, {31'd0, exp_gnt});
        was_busy = busy_m;
        done_eff = done && busy_m && !in_start;
        if (exp_gnt && wen) begin
            exp_q.push_back('{model_read(idx), id, ncyc + 1});
            if (idx == NR + 1) sticky_m = 1'b0;
        end
        if (exp_gnt && !wen) begin
            if (idx < NR) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) cfg_m[idx][8*b +: 8] = data[8*b +: 8];
            end
            if (idx == NR + 2) jobcnt_m = '0;
        end
        if (done_eff) begin
            sticky_m = 1'b1;
            jobcnt_m = jobcnt_m + 32'd1;
            busy_m   = 1'b0;
        end
        if (exp_gnt && !wen && idx == NR && !was_busy) begin
            busy_m     = 1'b1;
            trig_cycle = ncyc;
        end
    endtask

    task automatic wr(input logic [29:0] idx, input logic [31:0] data, input logic [3:0] be);
        cycle(1'b1, 1'b0, idx, be, data, '0, 1'b0);
    endtask

    task automatic rd(input logic [29:0] idx, input logic [IW-1:0] id);
        cycle(1'b1, 1'b1, idx, 4'hF, 32'd0, id, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 4'h0, 32'd0, '0, 1'b0);
    endtask

    task automatic run_job();
        wr(NR, $urandom, 4'hF);
        idle(3);
        cycle(1'b0, 1'b0, '0, 4'h0, 32'd0, '0, 1'b1);
        idle(1);
    endtask

    task automatic mid_cycle_reset();
        @(negedge clk_i);
        req_i  = 1'b0;
        done_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_busy_o", {31'd0, busy_o}, 32'd0);
        check("rst_start_o", {31'd0, start_o}, 32'd0);
        model_reset();
        exp_q.delete();
        check_cfg("rst_cfg_o");
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
    endtask

    // Response monitor: each negedge either a predicted response is due or outputs are quiet
    always @(negedge clk_i) begin
        rsp_t e;
        ncyc++;
        if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
            e = exp_q.pop_front();
            check("r_valid_o", {31'd0, r_valid_o}, 32'd1);
            check("r_data_o", r_data_o, e.data);
            check("r_id_o", {27'd0, r_id_o}, {27'd0, e.id});
        end else begin
            check("r_valid_o_idle", {31'd0, r_valid_o}, 32'd0);
            check("r_data_o_idle", r_data_o, 32'd0);
            check("r_id_o_idle", {27'd0, r_id_o}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i  = 1'b1;
        req_i  = 1'b0;
        wen_i  = 1'b0;
        add_i  = '0;
        be_i   = '0;
        data_i = '0;
        id_i   = '0;
        done_i = 1'b0;
        model_reset();
        #12;
        req_i = 1'b1;
        #1;
        check("gnt_in_reset_hi", {31'd0, gnt_o}, 32'd1);
        req_i = 1'b0;
        #1;
        check("gnt_in_reset_lo", {31'd0, gnt_o}, 32'd0);
        check("reset_busy_o", {31'd0, busy_o}, 32'd0);
        check_cfg("reset_cfg_o");
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;

        // CFG write/read and partial byte enables
        wr(2, 32'hDEADBEEF, 4'hF);
        rd(2, 5'd7);
        wr(0, 32'h11223344, 4'b0101);
        idle(1);
        check("cfg0_byte_enables", cfg_o[31:0], 32'h00220044);

        // Job with STATUS poll and a CFG write stalled until completion
        wr(NR, 32'hFFFF_FFFF, 4'hF);
        idle(1);
        rd(NR + 1, 5'd1);
        for (int i = 0; i < 3; i++) wr(1, 32'hCAFE0001, 4'hF);
        cycle(1'b1, 1'b0, 30'd1, 4'hF, 32'hCAFE0001, '0, 1'b1);
        wr(1, 32'hCAFE0001, 4'hF);
        rd(NR + 1, 5'd2);
        rd(NR + 1, 5'd3);
        rd(NR + 2, 5'd4);

        for (int j = 0; j < 3; j++) run_job();
        rd(NR + 2, 5'd5);

        // STATUS read in the completion cycle, then the sticky bit survives
        wr(NR, 32'd0, 4'hF);
        idle(2);
        cycle(1'b1, 1'b1, NR + 1, 4'hF, 32'd0, 5'd6, 1'b1);
        rd(NR + 1, 5'd8);

        // JOBCNT clear coinciding with completion; TRIGGER while RUNNING is ignored
        wr(NR, 32'd0, 4'hF);
        idle(2);
        wr(NR, 32'd0, 4'hF);
        idle(2);
        cycle(1'b1, 1'b0, NR + 2, 4'hF, 32'h1234, '0, 1'b1);
        idle(1);
        rd(NR + 2, 5'd9);

        // Reset during RUNNING with CFG loaded
        wr(3, 32'hA5A5A5A5, 4'hF);
        wr(NR, 32'd0, 4'hF);
        idle(2);
        mid_cycle_reset();
        rd(NR + 2, 5'd10);
        rd(NR + 5, 5'd11);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            int          r;
            logic [29:0] idx;
            r = $urandom_range(0, 99);
            if (r < 60)      idx = 30'($urandom_range(0, NR - 1));
            else if (r < 70) idx = NR;
            else if (r < 80) idx = NR + 1;
            else if (r < 88) idx = NR + 2;
            else             idx = 30'(NR + 3 + $urandom_range(0, 20));
            cycle($urandom_range(0, 99) < 75, 1'($urandom), idx, 4'($urandom), $urandom,
                  IW'($urandom), $urandom_range(0, 99) < 12);
        end
        idle(3);
        check("response_queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
